stall_ctrl: RTL and testbench

STALL_CTRL -- requirements
Module: stall_ctrl

---
 rtl/stall_ctrl.sv | 90 +++++++++
 tb/tb_stall_ctrl.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/stall_ctrl.sv
// rtl/stall_ctrl.sv - ID-stage RAW hazard detector with 3-entry destination scoreboard
// Optional feature macro: STALL_WB_BYPASS_EN (write-first register file, WB entry not compared)
module stall_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        id_valid,
  input  logic [4:0]  id_rs1,
  input  logic [4:0]  id_rs2,
  input  logic        id_rs1_used,
  input  logic        id_rs2_used,
  input  logic [4:0]  id_rd,
  input  logic        id_rd_we,
  input  logic        flush,
  output logic        stalling_signal,
  output logic        bubble,
  output logic [1:0]  hazard_stage,
  output logic [15:0] stall_cycles
);

  // Scoreboard of destinations for the instructions already past ID.
  // A valid entry always carries a nonzero rd, since x0 writes are never pushed.
  logic       ex_v, mem_v, wb_v;
  logic [4:0] ex_rd, mem_rd, wb_rd;

  logic       wb_cmp;
  logic       hit_ex, hit_mem, hit_wb;
  logic       src1_live, src2_live;
  logic       push;

`ifdef STALL_WB_BYPASS_EN
  // The register file writes before it is read, so a WB producer is already visible.
  assign wb_cmp = 1'b0;
`else
  assign wb_cmp = wb_v;
`endif

  assign src1_live = id_rs1_used & (id_rs1 != 5'd0);
  assign src2_live = id_rs2_used & (id_rs2 != 5'd0);

  assign hit_ex  = ex_v   & ((src1_live & (id_rs1 == ex_rd))  | (src2_live & (id_rs2 == ex_rd)));
  assign hit_mem = mem_v  & ((src1_live & (id_rs1 == mem_rd)) | (src2_live & (id_rs2 == mem_rd)));
  assign hit_wb  = wb_cmp & ((src1_live & (id_rs1 == wb_rd))  | (src2_live & (id_rs2 == wb_rd)));

  // Same-cycle stall decision; flush wins over a hazard and reset silences everything.
  always_comb begin
    stalling_signal = 1'b0;
    hazard_stage    = 2'd0;
    if (!rst && id_valid && !flush && (hit_ex || hit_mem || hit_wb)) begin
      stalling_signal = 1'b1;
      if (hit_ex)
        hazard_stage = 2'd1;
      else if (hit_mem)
        hazard_stage = 2'd2;
      else
        hazard_stage = 2'd3;
    end
  end

  assign bubble = !rst & (stalling_signal | flush);

  assign push = id_valid & id_rd_we & (id_rd != 5'd0) & !stalling_signal & !flush;

  // Advance the scoreboard every cycle; a stalled or killed instruction leaves a hole in EX.
  always_ff @(posedge clk) begin
    if (rst) begin
      ex_v   <= 1'b0;
      mem_v  <= 1'b0;
      wb_v   <= 1'b0;
      ex_rd  <= 5'd0;
      mem_rd <= 5'd0;
      wb_rd  <= 5'd0;
    end else begin
      wb_v   <= mem_v;
      wb_rd  <= mem_rd;
      mem_v  <= ex_v;
      mem_rd <= ex_rd;
      ex_v   <= push;
      ex_rd  <= push ? id_rd : 5'd0;
    end
  end

  // Saturating stall-cycle counter for performance monitoring.
  always_ff @(posedge clk) begin
    if (rst)
      stall_cycles <= 16'd0;
    else if (stalling_signal && (stall_cycles != 16'hFFFF))
      stall_cycles <= stall_cycles + 16'd1;
  end

endmodule

// File: tb/tb_stall_ctrl.sv
// tb/tb_stall_ctrl.sv - scoreboard-checked random and directed bench for stall_ctrl
module tb_stall_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        id_valid;
  logic [4:0]  id_rs1, id_rs2, id_rd;
  logic        id_rs1_used, id_rs2_used, id_rd_we, flush;
  logic        stalling_signal, bubble;
  logic [1:0]  hazard_stage;
  logic [15:0] stall_cycles;

  stall_ctrl dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used), .id_rd(id_rd), .id_rd_we(id_rd_we),
    .flush(flush), .stalling_signal(stalling_signal), .bubble(bubble),
    .hazard_stage(hazard_stage), .stall_cycles(stall_cycles)
  );

  always #5 clk = ~clk;

`ifdef STALL_WB_BYPASS_EN
  localparam int WIN = 2;
`else
  localparam int WIN = 3;
`endif

  typedef struct packed {
    logic        st;
    logic        bu;
    logic [1:0]  hs;
    logic [15:0] cnt;
    logic        ck_cnt;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  // Reference model: destinations written by the instructions issued 1, 2, 3 cycles ago (0 = none).
  int   hist[3];
  int   m_cnt;
  bit   cnt_known;

  task automatic chk(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, req);
    end
  endtask

  // Monitor: every cycle the DUT presents a decision; compare it against the oldest prediction.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("stalling_signal", int'(stalling_signal), int'(e.st));
        chk("bubble", int'(bubble), int'(e.bu));
        chk("hazard_stage", int'(hazard_stage), int'(e.hs));
        if (e.ck_cnt) chk("stall_cycles", int'(stall_cycles), int'(e.cnt));
      end
    end
  end

  // One cycle: drive inputs, predict outputs from the model, clock, then advance the model.
  task automatic step(input bit r, input bit v, input int rs1, input bit u1, input int rs2,
                      input bit u2, input int rd, input bit we, input bit fl);
    exp_t e;
    int   near;
    bit   st;
    rst = r; id_valid = v; id_rs1 = 5'(rs1); id_rs1_used = u1; id_rs2 = 5'(rs2);
    id_rs2_used = u2; id_rd = 5'(rd); id_rd_we = we; flush = fl;
    near = 99;
    for (int k = 0; k < WIN; k++) begin
      if ((u1 && rs1 != 0 && hist[k] == rs1) || (u2 && rs2 != 0 && hist[k] == rs2))
        if (k < near) near = k;
    end
    st = !r && v && !fl && (near != 99);
    e.st = st;
    e.bu = !r && (st || fl);
    e.hs = st ? 2'(near + 1) : 2'd0;
    e.cnt = 16'(m_cnt);
    e.ck_cnt = cnt_known;
    exp_q.push_back(e);
    @(posedge clk);
    if (r) begin
      hist = '{0, 0, 0};
      m_cnt = 0;
      cnt_known = 1'b1;
    end else begin
      if (st && m_cnt < 65535) m_cnt++;
      hist[2] = hist[1];
      hist[1] = hist[0];
      hist[0] = (v && we && rd != 0 && !st && !fl) ? rd : 0;
    end
    #1;
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic drain();
    int guard = 0;
    while (exp_q.size() > 0 && guard < 10) begin
      @(negedge clk);
      guard++;
    end
    #1;
    chk("queue_drained", exp_q.size(), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, pending=%0d", exp_q.size());
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int guard;
    hist = '{0, 0, 0};
    m_cnt = 0;
    cnt_known = 1'b0;
    rst = 1'b1; id_valid = 0; id_rs1 = 0; id_rs2 = 0; id_rs1_used = 0; id_rs2_used = 0;
    id_rd = 0; id_rd_we = 0; flush = 0;
    @(posedge clk); #1;
    step(1, 1, 3, 1, 3, 1, 3, 1, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0);
    idle();
    drain();
    chk("reset_count", int'(stall_cycles), 0);

    // addi x5,x1,imm then add x6,x5,x1 waiting in ID until x5 leaves the window
    step(0, 1, 1, 1, 0, 0, 5, 1, 0);
    for (int i = 0; i <= WIN; i++) step(0, 1, 5, 1, 1, 1, 6, 1, 0);
    idle();
    drain();
    chk("raw_stall_total", int'(stall_cycles), WIN);

    // x0 producer and x0 consumer never interact
    step(0, 1, 1, 1, 0, 0, 0, 1, 0);
    step(0, 1, 0, 1, 0, 1, 7, 1, 0);
    idle();

    // flush beats a hazard; the killed instruction leaves EX empty
    step(0, 1, 1, 1, 0, 0, 9, 1, 0);
    step(0, 1, 9, 1, 0, 0, 10, 1, 1);
    step(0, 1, 10, 1, 0, 0, 11, 1, 0);
    for (int i = 0; i < 4; i++) idle();

    // reset in the middle of a stall, then the same consumer proceeds
    step(0, 1, 1, 1, 0, 0, 12, 1, 0);
    step(0, 1, 12, 1, 0, 0, 13, 1, 0);
    step(0, 1, 12, 1, 0, 0, 13, 1, 0);
    step(1, 1, 12, 1, 0, 0, 13, 1, 0);
    drain();
    chk("count_after_reset", int'(stall_cycles), 0);
    step(0, 1, 12, 1, 0, 0, 13, 1, 0);
    for (int i = 0; i < 4; i++) idle();

    // dual-source dependency on different stages
    step(0, 1, 0, 0, 0, 0, 14, 1, 0);
    step(0, 1, 0, 0, 0, 0, 15, 1, 0);
    for (int i = 0; i < 3; i++) step(0, 1, 14, 1, 15, 1, 16, 1, 0);
    for (int i = 0; i < 4; i++) idle();

    // randomized traffic over a small register set to provoke frequent hazards
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 99) < 2), ($urandom_range(0, 9) < 8),
           int'($urandom_range(0, 4)), 1'($urandom), int'($urandom_range(0, 4)), 1'($urandom),
           int'($urandom_range(0, 4)), ($urandom_range(0, 9) < 7), ($urandom_range(0, 9) == 0));
    end
    step(1, 0, 0, 0, 0, 0, 0, 0, 0);

    // self-dependent instruction stalls WIN of every WIN+1 cycles until the counter pins
    guard = 0;
    while (m_cnt < 65535 && guard < 95000) begin
      step(0, 1, 5, 1, 0, 0, 5, 1, 0);
      guard++;
    end
    chk("saturation_reached", m_cnt, 65535);
    for (int i = 0; i < 3 * (WIN + 1); i++) step(0, 1, 5, 1, 0, 0, 5, 1, 0);
    idle();
    drain();
    chk("saturated_count", int'(stall_cycles), 65535);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
